sub_top_conv: RTL and testbench

Convolution sub-top holding one IFM buffer, 16 per-PE weight buffers, an address generator and 16 int8 MAC processing elements (PEs). Each PE computes one output channel of a 3x3xC convolution, consuming 4 bytes per cycle. One output pixel takes 36 cycles at C=16. Sits between the host/DMA load path and the OFM writeback path of the fused CNN block.

---
 rtl/sub_top_conv.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sub_top_conv.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_top_conv.sv
// Convolution sub-top: IFM buffer, 16 weight buffers, window address generator, 16 int8 MAC PEs.
// Latency: first MAC 3 cycles after start; result/valid the cycle after PE_finish. No backpressure; optional RELU_EN clamps OFM_n at 0.
module sub_top_conv #(
    parameter int IFM_W       = 58,
    parameter int IFM_H       = 58,
    parameter int IFM_C       = 16,
    parameter int K           = 3,
    parameter int NUM_PE      = 16,
    parameter int FILT_PER_PE = 2,
    parameter int OUT_SHIFT   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_IFM,
    input  logic        we_weight,
    input  logic [31:0] addr,
    input  logic [31:0] data_in_IFM,
    input  logic [31:0] data_in_Weight_0,
    input  logic [31:0] data_in_Weight_1,
    input  logic [31:0] data_in_Weight_2,
    input  logic [31:0] data_in_Weight_3,
    input  logic [31:0] data_in_Weight_4,
    input  logic [31:0] data_in_Weight_5,
    input  logic [31:0] data_in_Weight_6,
    input  logic [31:0] data_in_Weight_7,
    input  logic [31:0] data_in_Weight_8,
    input  logic [31:0] data_in_Weight_9,
    input  logic [31:0] data_in_Weight_10,
    input  logic [31:0] data_in_Weight_11,
    input  logic [31:0] data_in_Weight_12,
    input  logic [31:0] data_in_Weight_13,
    input  logic [31:0] data_in_Weight_14,
    input  logic [31:0] data_in_Weight_15,
    input  logic        cal_start,
    input  logic [15:0] PE_reset,
    input  logic [15:0] PE_finish,
    output logic [31:0] OFM,
    output logic [15:0] valid,
    output logic [31:0] done_window,
    output logic [7:0]  OFM_0,
    output logic [7:0]  OFM_1,
    output logic [7:0]  OFM_2,
    output logic [7:0]  OFM_3,
    output logic [7:0]  OFM_4,
    output logic [7:0]  OFM_5,
    output logic [7:0]  OFM_6,
    output logic [7:0]  OFM_7,
    output logic [7:0]  OFM_8,
    output logic [7:0]  OFM_9,
    output logic [7:0]  OFM_10,
    output logic [7:0]  OFM_11,
    output logic [7:0]  OFM_12,
    output logic [7:0]  OFM_13,
    output logic [7:0]  OFM_14,
    output logic [7:0]  OFM_15
);

    localparam int CG        = IFM_C / 4;
    localparam int OUT_W     = IFM_W - K + 1;
    localparam int OUT_H     = IFM_H - K + 1;
    localparam int WPF       = K * K * CG;
    localparam int IFM_DEPTH = IFM_W * IFM_H * CG;
    localparam int W_DEPTH   = FILT_PER_PE * WPF;
    localparam int IFM_AW    = $clog2(IFM_DEPTH);
    localparam int W_AW      = $clog2(W_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [15:0] cg_c, kx_c, ky_c, ox_c, oy_c, f_c;
    logic        issue, window_last, last_issue;
    logic [IFM_AW-1:0] ifm_addr_nxt, ifm_addr_q;
    logic [W_AW-1:0]   w_addr_nxt, w_addr_q;
    logic        rd_vld, mac_vld;

    logic [31:0] ifm_mem [IFM_DEPTH];
    logic [31:0] w_mem   [NUM_PE][W_DEPTH];
    logic [31:0] w_din   [NUM_PE];
    logic [31:0] ifm_rd;
    logic [31:0] w_rd    [NUM_PE];

    logic signed [31:0] acc     [NUM_PE];
    logic signed [31:0] acc_sum [NUM_PE];
    logic [7:0]         ofm_q   [NUM_PE];

    always_comb begin
        w_din[0]  = data_in_Weight_0;
        w_din[1]  = data_in_Weight_1;
        w_din[2]  = data_in_Weight_2;
        w_din[3]  = data_in_Weight_3;
        w_din[4]  = data_in_Weight_4;
        w_din[5]  = data_in_Weight_5;
        w_din[6]  = data_in_Weight_6;
        w_din[7]  = data_in_Weight_7;
        w_din[8]  = data_in_Weight_8;
        w_din[9]  = data_in_Weight_9;
        w_din[10] = data_in_Weight_10;
        w_din[11] = data_in_Weight_11;
        w_din[12] = data_in_Weight_12;
        w_din[13] = data_in_Weight_13;
        w_din[14] = data_in_Weight_14;
        w_din[15] = data_in_Weight_15;
    end

    assign OFM_0  = ofm_q[0];
    assign OFM_1  = ofm_q[1];
    assign OFM_2  = ofm_q[2];
    assign OFM_3  = ofm_q[3];
    assign OFM_4  = ofm_q[4];
    assign OFM_5  = ofm_q[5];
    assign OFM_6  = ofm_q[6];
    assign OFM_7  = ofm_q[7];
    assign OFM_8  = ofm_q[8];
    assign OFM_9  = ofm_q[9];
    assign OFM_10 = ofm_q[10];
    assign OFM_11 = ofm_q[11];
    assign OFM_12 = ofm_q[12];
    assign OFM_13 = ofm_q[13];
    assign OFM_14 = ofm_q[14];
    assign OFM_15 = ofm_q[15];

    function automatic logic signed [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
        logic signed [7:0]  pa, pb;
        logic signed [15:0] p;
        logic signed [31:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            pa = a[8*i +: 8];
            pb = b[8*i +: 8];
            p  = pa * pb;
            s  = s + {{16{p[15]}}, p};
        end
        return s;
    endfunction

    function automatic logic [7:0] quant(input logic signed [31:0] v);
        logic signed [31:0] q;
        q = v >>> OUT_SHIFT;
`ifdef RELU_EN
        if (q < 0) q = '0;
`endif
        if (q > 127)       return 8'h7f;
        else if (q < -128) return 8'h80;
        else               return q[7:0];
    endfunction

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    assign issue       = (state == RUN) && cal_start;
    assign window_last = (cg_c == 16'(CG - 1)) && (kx_c == 16'(K - 1)) && (ky_c == 16'(K - 1));
    assign last_issue  = window_last && (ox_c == 16'(OUT_W - 1)) && (oy_c == 16'(OUT_H - 1)) &&
                         (f_c == 16'(FILT_PER_PE - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cal_start) state_nxt = RUN;
            RUN:     if (!cal_start) state_nxt = IDLE;
                     else if (last_issue) state_nxt = DONE;
            DONE:    if (!cal_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- address generator ----------------
    always_comb begin
        ifm_addr_nxt = IFM_AW'(((32'(oy_c) + 32'(ky_c)) * 32'(IFM_W) + 32'(ox_c) + 32'(kx_c))
                               * 32'(CG) + 32'(cg_c));
        w_addr_nxt   = W_AW'(32'(f_c) * 32'(WPF) + 32'(ky_c) * 32'(K * CG) +
                             32'(kx_c) * 32'(CG) + 32'(cg_c));
    end

    // Counters run cg fastest, then kx, ky, ox, oy, f; they sit at zero outside an active issue.
    always_ff @(posedge clk) begin
        if (!reset || !issue) begin
            cg_c <= '0; kx_c <= '0; ky_c <= '0;
            ox_c <= '0; oy_c <= '0; f_c  <= '0;
        end else if (cg_c != 16'(CG - 1)) begin
            cg_c <= cg_c + 16'd1;
        end else begin
            cg_c <= '0;
            if (kx_c != 16'(K - 1)) kx_c <= kx_c + 16'd1;
            else begin
                kx_c <= '0;
                if (ky_c != 16'(K - 1)) ky_c <= ky_c + 16'd1;
                else begin
                    ky_c <= '0;
                    if (ox_c != 16'(OUT_W - 1)) ox_c <= ox_c + 16'd1;
                    else begin
                        ox_c <= '0;
                        if (oy_c != 16'(OUT_H - 1)) oy_c <= oy_c + 16'd1;
                        else begin
                            oy_c <= '0;
                            f_c  <= f_c + 16'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ifm_addr_q <= '0;
            w_addr_q   <= '0;
            rd_vld     <= 1'b0;
            mac_vld    <= 1'b0;
        end else begin
            if (issue) begin
                ifm_addr_q <= ifm_addr_nxt;
                w_addr_q   <= w_addr_nxt;
            end
            rd_vld  <= issue;
            mac_vld <= rd_vld;
        end
    end

    // ---------------- buffers (contents survive reset) ----------------
    always_ff @(posedge clk) begin
        if (we_IFM && state != RUN && addr < 32'(IFM_DEPTH))
            ifm_mem[addr[IFM_AW-1:0]] <= data_in_IFM;
        if (we_weight && state != RUN && addr < 32'(W_DEPTH))
            for (int n = 0; n < NUM_PE; n++) w_mem[n][addr[W_AW-1:0]] <= w_din[n];
        ifm_rd <= ifm_mem[ifm_addr_q];
        for (int n = 0; n < NUM_PE; n++) w_rd[n] <= w_mem[n][w_addr_q];
    end

    // ---------------- processing elements ----------------
    always_comb begin
        for (int n = 0; n < NUM_PE; n++)
            acc_sum[n] = acc[n] + (mac_vld ? dot4(ifm_rd, w_rd[n]) : 32'sd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < NUM_PE; n++) begin
                acc[n]   <= '0;
                ofm_q[n] <= '0;
            end
            valid       <= '0;
            OFM         <= '0;
            done_window <= '0;
        end else begin
            valid <= '0;
            for (int n = 0; n < NUM_PE; n++) begin
                if (PE_reset[n]) begin
                    acc[n] <= '0;
                end else if (PE_finish[n]) begin
                    acc[n]   <= '0;
                    ofm_q[n] <= quant(acc_sum[n]);
                    valid[n] <= 1'b1;
                end else begin
                    acc[n] <= acc_sum[n];
                end
            end
            if (PE_finish[0] && !PE_reset[0]) OFM <= acc_sum[0];
            if (PE_finish[0]) done_window <= done_window + 32'd1;
        end
    end

endmodule

// File: tb/tb_sub_top_conv.sv
// Directed bench for sub_top_conv: hand-computed window results, pulse spacing, PE clear and reset abort.
module tb_sub_top_conv;
    localparam int W  = 58;
    localparam int CG = 4;

    logic        clk = 1'b0;
    logic        reset, we_IFM, we_weight, cal_start;
    logic [31:0] addr, data_in_IFM;
    logic [31:0] wd [16];
    logic [15:0] PE_reset, PE_finish;
    logic [31:0] OFM, done_window;
    logic [15:0] valid;
    logic [7:0]  o8 [16];
    logic [127:0] ofm_all;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sub_top_conv dut (
        .clk(clk), .reset(reset), .we_IFM(we_IFM), .we_weight(we_weight), .addr(addr),
        .data_in_IFM(data_in_IFM),
        .data_in_Weight_0(wd[0]),   .data_in_Weight_1(wd[1]),   .data_in_Weight_2(wd[2]),
        .data_in_Weight_3(wd[3]),   .data_in_Weight_4(wd[4]),   .data_in_Weight_5(wd[5]),
        .data_in_Weight_6(wd[6]),   .data_in_Weight_7(wd[7]),   .data_in_Weight_8(wd[8]),
        .data_in_Weight_9(wd[9]),   .data_in_Weight_10(wd[10]), .data_in_Weight_11(wd[11]),
        .data_in_Weight_12(wd[12]), .data_in_Weight_13(wd[13]), .data_in_Weight_14(wd[14]),
        .data_in_Weight_15(wd[15]),
        .cal_start(cal_start), .PE_reset(PE_reset), .PE_finish(PE_finish),
        .OFM(OFM), .valid(valid), .done_window(done_window),
        .OFM_0(o8[0]),   .OFM_1(o8[1]),   .OFM_2(o8[2]),   .OFM_3(o8[3]),
        .OFM_4(o8[4]),   .OFM_5(o8[5]),   .OFM_6(o8[6]),   .OFM_7(o8[7]),
        .OFM_8(o8[8]),   .OFM_9(o8[9]),   .OFM_10(o8[10]), .OFM_11(o8[11]),
        .OFM_12(o8[12]), .OFM_13(o8[13]), .OFM_14(o8[14]), .OFM_15(o8[15])
    );

    always_comb begin
        ofm_all = '0;
        for (int i = 0; i < 16; i++) ofm_all[8*i +: 8] = o8[i];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sys_reset();
        reset = 1'b0; cal_start = 1'b0; PE_reset = '0; PE_finish = '0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic load_ifm(input logic [31:0] v);
        we_IFM = 1'b1;
        for (int a = 0; a < 3 * W * CG; a++) begin
            addr = a; data_in_IFM = v;
            tick();
        end
        we_IFM = 1'b0;
    endtask

    // pe0_only: PE0 word 0 = 0x02000000, everything else zero
    task automatic load_w(input logic [31:0] v, input bit pe0_only);
        we_weight = 1'b1;
        for (int j = 0; j < 36; j++) begin
            addr = j;
            for (int n = 0; n < 16; n++)
                wd[n] = pe0_only ? ((n == 0 && j == 0) ? 32'h0200_0000 : 32'h0) : v;
            tick();
        end
        we_weight = 1'b0;
    endtask

    // C0 edge, then PE_finish sampled at C0+38
    task automatic run_one_window();
        cal_start = 1'b1;
        tick();
        repeat (37) tick();
        PE_finish = '1;
        tick();
        PE_finish = '0;
    endtask

    logic [7:0]   neg_q;
    logic [127:0] e5;
    int pulse_ok, pulse_bad, raw_bad;

    initial begin
        reset = 1'b0; we_IFM = 1'b0; we_weight = 1'b0; cal_start = 1'b0;
        addr = '0; data_in_IFM = '0; PE_reset = '0; PE_finish = '0;
        for (int n = 0; n < 16; n++) wd[n] = '0;
`ifdef RELU_EN
        neg_q = 8'h00;
`else
        neg_q = 8'h80;
`endif

        // reset state
        sys_reset();
        chk("rst_ofm", 128'(OFM), 128'h0);
        chk("rst_valid", 128'(valid), 128'h0);
        chk("rst_done", 128'(done_window), 128'h0);
        chk("rst_ofm_n", ofm_all, 128'h0);

        // all ones: 36 words * 4 = 144
        load_ifm(32'h0101_0101);
        load_w(32'h0101_0101, 1'b0);
        run_one_window();
        chk("t1_valid", 128'(valid), 128'hffff);
        chk("t1_ofm", 128'(OFM), 128'h90);
        chk("t1_ofm_n", ofm_all, {16{8'h7f}});
        chk("t1_done", 128'(done_window), 128'h1);
        tick();
        chk("t1_valid_1cyc", 128'(valid), 128'h0);
        cal_start = 1'b0; tick();

        // single weight byte on PE0
        sys_reset();
        load_w(32'h0, 1'b1);
        run_one_window();
        chk("t2_ofm", 128'(OFM), 128'h2);
        chk("t2_ofm_n", ofm_all, 128'h02);
        cal_start = 1'b0; tick();

        // negative: -1 * 1 per byte -> -144
        sys_reset();
        load_ifm(32'hffff_ffff);
        load_w(32'h0101_0101, 1'b0);
        run_one_window();
        chk("t3_ofm", 128'(OFM), 128'hffff_ff70);
        chk("t3_ofm_n", ofm_all, {16{neg_q}});
        cal_start = 1'b0; tick();

        // 50 back-to-back windows
        sys_reset();
        pulse_ok = 0; pulse_bad = 0; raw_bad = 0;
        cal_start = 1'b1;
        tick();
        repeat (37) tick();
        for (int w = 0; w < 50; w++) begin
            PE_finish = '1;
            tick();
            PE_finish = '0;
            if (valid === 16'hffff) pulse_ok++;
            else pulse_bad++;
            if (OFM !== 32'hffff_ff70) raw_bad++;
            repeat (35) begin
                tick();
                if (valid !== 16'h0) pulse_bad++;
            end
        end
        chk("t4_pulses", 128'(pulse_ok), 128'd50);
        chk("t4_bad_pulses", 128'(pulse_bad), 128'd0);
        chk("t4_raw_bad", 128'(raw_bad), 128'd0);
        chk("t4_done", 128'(done_window), 128'd50);
        chk("t4_ofm_n", ofm_all, {16{neg_q}});
        cal_start = 1'b0; tick();

        // PE3 cleared at the edge of word 9: only words 10..35 count (26*4 = 104)
        sys_reset();
        load_w(32'hffff_ffff, 1'b0);
        cal_start = 1'b1;
        tick();
        repeat (11) tick();
        PE_reset = 16'h0008;
        tick();
        PE_reset = '0;
        repeat (25) tick();
        PE_finish = '1;
        tick();
        PE_finish = '0;
        e5 = {16{8'h7f}};
        e5[31:24] = 8'h68;
        chk("t5_ofm_n", ofm_all, e5);
        chk("t5_ofm", 128'(OFM), 128'h90);
        chk("t5_valid", 128'(valid), 128'hffff);

        // reset mid-run, then restart from window 0
        repeat (20) tick();
        reset = 1'b0; cal_start = 1'b0;
        tick();
        chk("t6_ofm", 128'(OFM), 128'h0);
        chk("t6_valid", 128'(valid), 128'h0);
        chk("t6_done", 128'(done_window), 128'h0);
        chk("t6_ofm_n", ofm_all, 128'h0);
        reset = 1'b1;
        tick();
        run_one_window();
        chk("t6_restart_ofm", 128'(OFM), 128'h90);
        chk("t6_restart_done", 128'(done_window), 128'h1);
        cal_start = 1'b0; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
